// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the core memory bus port
// MEM stage has priority; a starvation counter forces an IF grant after IF_STARVE_MAX MEM wins.
module mem_port_arbiter #(
  parameter int IF_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [63:0] if_addr,
  input  logic [1:0]  if_size,
  output logic        if_ready,
  output logic [1:0]  if_resp,
  output logic [63:0] if_data_read,
  input  logic        mem_valid,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_wdata,
  output logic        mem_ready,
  output logic [1:0]  mem_resp,
  output logic [63:0] mem_data_read,
  output logic        rw_valid,
  output logic        rw_req,
  output logic [63:0] rw_addr,
  output logic [1:0]  rw_size,
  output logic [63:0] rw_w_data,
  input  logic        rw_ready,
  input  logic [1:0]  rw_resp,
  input  logic [63:0] rw_data_read
);

  localparam int CW = $clog2(IF_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(IF_STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;

  // Only a MEM win over a pending IF counts toward starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid && (!if_valid || starve_cnt < STARVE_LIMIT)) begin
            state <= MEM_BUSY;
            if (if_valid) starve_cnt <= starve_cnt + CW'(1);
          end else if (if_valid) begin
            state      <= IF_BUSY;
            starve_cnt <= '0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (rw_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus fields follow the owner's live inputs for the whole transaction.
  always_comb begin
    rw_valid  = 1'b0;
    rw_req    = 1'b0;
    rw_addr   = '0;
    rw_size   = '0;
    rw_w_data = '0;
    if_ready  = 1'b0;
    mem_ready = 1'b0;
    case (state)
      IF_BUSY: begin
        rw_valid = 1'b1;
        rw_addr  = if_addr;
        rw_size  = if_size;
        if_ready = rw_ready;
      end
      MEM_BUSY: begin
        rw_valid  = 1'b1;
        rw_req    = mem_req;
        rw_addr   = mem_addr;
        rw_size   = mem_size;
        rw_w_data = mem_wdata;
        mem_ready = rw_ready;
      end
      default: ;
    endcase
  end

  assign if_data_read  = rw_data_read;
  assign mem_data_read = rw_data_read;
  assign if_resp       = rw_resp;
  assign mem_resp      = rw_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// The bench acts as the bus: each grant is popped from the expected queue and completed.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, mem_valid, mem_req, rw_ready;
  logic [63:0] if_addr, mem_addr, mem_wdata, rw_data_read;
  logic [1:0]  if_size, mem_size, rw_resp;
  logic        if_ready, mem_ready, rw_valid, rw_req;
  logic [1:0]  if_resp, mem_resp, rw_size;
  logic [63:0] if_data_read, mem_data_read, rw_addr, rw_w_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_mem;
    logic        req;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.IF_STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size),
    .if_ready(if_ready), .if_resp(if_resp), .if_data_read(if_data_read),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_data_read(mem_data_read),
    .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr), .rw_size(rw_size),
    .rw_w_data(rw_w_data), .rw_ready(rw_ready), .rw_resp(rw_resp),
    .rw_data_read(rw_data_read)
  );

  task automatic push_exp(input bit is_mem, input logic req, input logic [63:0] addr,
                          input logic [1:0] size, input logic [63:0] wdata);
    exp_t e;
    e.is_mem = is_mem; e.req = req; e.addr = addr; e.size = size; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Wait for a grant, compare against the queue head, complete it, then check the bubble.
  task automatic serve(input logic [63:0] rdata, input logic [1:0] resp, input bit drop_owner);
    exp_t e;
    bit   got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rw_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      $display("FAIL grant_timeout rw_valid=%b required 1", rw_valid);
      errors++;
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_grant rw_addr=%h required no grant", rw_addr);
      errors++;
      return;
    end
    e = sb.pop_front();
    checks++;
    if (rw_req !== e.req) begin
      $display("FAIL rw_req got=%b exp=%b", rw_req, e.req); errors++;
    end
    checks++;
    if (rw_addr !== e.addr) begin
      $display("FAIL rw_addr got=%h exp=%h", rw_addr, e.addr); errors++;
    end
    checks++;
    if (rw_size !== e.size) begin
      $display("FAIL rw_size got=%h exp=%h", rw_size, e.size); errors++;
    end
    checks++;
    if (rw_w_data !== e.wdata) begin
      $display("FAIL rw_w_data got=%h exp=%h", rw_w_data, e.wdata); errors++;
    end
    rw_ready = 1'b1; rw_data_read = rdata; rw_resp = resp;
    #1;
    checks++;
    if (if_ready !== !e.is_mem || mem_ready !== e.is_mem) begin
      $display("FAIL ready_route if_ready=%b mem_ready=%b exp_mem_owner=%b",
               if_ready, mem_ready, e.is_mem);
      errors++;
    end
    checks++;
    if (e.is_mem ? (mem_data_read !== rdata || mem_resp !== resp)
                 : (if_data_read !== rdata || if_resp !== resp)) begin
      $display("FAIL read_data got_if=%h got_mem=%h resp_if=%h resp_mem=%h exp=%h/%h",
               if_data_read, mem_data_read, if_resp, mem_resp, rdata, resp);
      errors++;
    end
    if (drop_owner) begin
      if (e.is_mem) mem_valid = 1'b0; else if_valid = 1'b0;
    end
    @(posedge clk); #1;
    rw_ready = 1'b0; rw_data_read = '0; rw_resp = '0;
    @(negedge clk);
    checks++;
    if (rw_valid !== 1'b0 || if_ready !== 1'b0 || mem_ready !== 1'b0) begin
      $display("FAIL bubble rw_valid=%b if_ready=%b mem_ready=%b exp 0/0/0",
               rw_valid, if_ready, mem_ready);
      errors++;
    end
  endtask

  task automatic check_cnt(input string name, input logic [1:0] exp);
    checks++;
    if (dut.starve_cnt !== exp) begin
      $display("FAIL %s starve_cnt got=%0d exp=%0d", name, dut.starve_cnt, exp); errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_valid = 0; if_addr = '0; if_size = '0;
    mem_valid = 0; mem_req = 0; mem_addr = '0; mem_size = '0; mem_wdata = '0;
    rw_ready = 0; rw_resp = '0; rw_data_read = '0;
    #1;
    checks++;
    if (rw_valid !== 0 || rw_req !== 0 || if_ready !== 0 || mem_ready !== 0) begin
      $display("FAIL reset_ctrl rw_valid=%b rw_req=%b if_ready=%b mem_ready=%b exp 0",
               rw_valid, rw_req, if_ready, mem_ready);
      errors++;
    end
    checks++;
    if (rw_addr !== '0 || rw_size !== '0 || rw_w_data !== '0) begin
      $display("FAIL reset_data rw_addr=%h rw_size=%h rw_w_data=%h exp 0",
               rw_addr, rw_size, rw_w_data);
      errors++;
    end
    check_cnt("reset", 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_if_read();
    @(negedge clk);
    if_valid = 1; if_addr = 64'h8000_0000; if_size = 2'd2;
    push_exp(0, 0, 64'h8000_0000, 2'd2, 64'h0);
    #1;
    checks++;
    if (rw_valid !== 1'b0) begin
      $display("FAIL grant_early rw_valid=%b exp 0", rw_valid); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (rw_valid !== 1'b1) begin
      $display("FAIL grant_latency rw_valid=%b exp 1", rw_valid); errors++;
    end
    serve(64'h0000_0013, 2'd0, 1);
    check_cnt("if_read", 2'd0);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_valid = 1; if_addr = 64'h8000_0040; if_size = 2'd2;
    mem_valid = 1; mem_req = 1; mem_addr = 64'h8000_1000; mem_size = 2'd3;
    mem_wdata = 64'hDEAD_BEEF;
    push_exp(1, 1, 64'h8000_1000, 2'd3, 64'hDEAD_BEEF);
    push_exp(0, 0, 64'h8000_0040, 2'd2, 64'h0);
    serve(64'h0, 2'd0, 1);
    check_cnt("simul_mem", 2'd1);
    serve(64'h0000_0093, 2'd1, 1);
    check_cnt("simul_if", 2'd0);
  endtask

  task automatic test_starvation();
    @(negedge clk);
    if_valid = 1; if_addr = 64'h8000_0080; if_size = 2'd2;
    mem_valid = 1; mem_req = 0; mem_addr = 64'h8000_2000; mem_size = 2'd3; mem_wdata = 64'h55;
    push_exp(1, 0, 64'h8000_2000, 2'd3, 64'h55);
    push_exp(1, 0, 64'h8000_2000, 2'd3, 64'h55);
    push_exp(0, 0, 64'h8000_0080, 2'd2, 64'h0);
    serve(64'hA1, 2'd0, 0);
    check_cnt("starve_1", 2'd1);
    serve(64'hA2, 2'd0, 0);
    check_cnt("starve_2", 2'd2);
    serve(64'hA3, 2'd0, 1);
    mem_valid = 0;
    check_cnt("starve_if", 2'd0);
  endtask

  task automatic test_mem_read();
    @(negedge clk);
    mem_valid = 1; mem_req = 0; mem_addr = 64'h0000_0000_1234_5678; mem_size = 2'd1;
    mem_wdata = 64'hFFFF;
    push_exp(1, 0, 64'h0000_0000_1234_5678, 2'd1, 64'hFFFF);
    serve(64'h1122_3344_5566_7788, 2'd2, 1);
    check_cnt("mem_only", 2'd0);
  endtask

  task automatic test_owner_drop();
    @(negedge clk);
    if_valid = 1; if_addr = 64'h8000_0100; if_size = 2'd2;
    push_exp(0, 0, 64'h8000_0100, 2'd2, 64'h0);
    @(posedge clk);
    @(negedge clk);
    if_valid = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (rw_valid !== 1'b1 || if_ready !== 1'b0) begin
        $display("FAIL hold_after_drop rw_valid=%b if_ready=%b exp 1/0", rw_valid, if_ready);
        errors++;
      end
    end
    serve(64'h0000_0017, 2'd0, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0 || rw_valid !== 1'b0) begin
        $display("FAIL single_pulse if_ready=%b rw_valid=%b exp 0/0", if_ready, rw_valid);
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_valid = 1; mem_req = 1; mem_addr = 64'h8000_3000; mem_size = 2'd3; mem_wdata = 64'h77;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rw_valid !== 1'b1) begin
      $display("FAIL mid_grant rw_valid=%b exp 1", rw_valid); errors++;
    end
    mem_valid = 0;
    rst = 1'b0;
    #1;
    checks++;
    if (rw_valid !== 0 || rw_req !== 0 || rw_addr !== '0 || rw_w_data !== '0) begin
      $display("FAIL async_reset rw_valid=%b rw_req=%b rw_addr=%h rw_w_data=%h exp 0",
               rw_valid, rw_req, rw_addr, rw_w_data);
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rw_ready = 1; rw_data_read = 64'hBAD; rw_resp = 2'd3;
    #1;
    checks++;
    if (mem_ready !== 0 || if_ready !== 0) begin
      $display("FAIL stray_after_reset mem_ready=%b if_ready=%b exp 0/0", mem_ready, if_ready);
      errors++;
    end
    @(posedge clk); #1;
    rw_ready = 0; rw_data_read = '0; rw_resp = '0;
    @(negedge clk);
    checks++;
    if (rw_valid !== 1'b0) begin
      $display("FAIL idle_after_stray rw_valid=%b exp 0", rw_valid); errors++;
    end
  endtask

  task automatic test_stray();
    @(negedge clk);
    rw_ready = 1; rw_data_read = 64'hCAFE; rw_resp = 2'd1;
    repeat (3) begin
      #1;
      checks++;
      if (if_ready !== 0 || mem_ready !== 0 || rw_valid !== 0) begin
        $display("FAIL stray_idle if_ready=%b mem_ready=%b rw_valid=%b exp 0/0/0",
                 if_ready, mem_ready, rw_valid);
        errors++;
      end
      @(negedge clk);
    end
    rw_ready = 0; rw_data_read = '0; rw_resp = '0;
    check_cnt("stray", 2'd0);
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_simultaneous();
    test_starvation();
    test_mem_read();
    test_owner_drop();
    test_reset_mid();
    test_stray();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover entries=%0d exp 0", sb.size()); errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
